// File: rtl/egress_read_ctrl.sv
// Per-port frame reader: walks a descriptor's block chain and streams payload bytes to the TX MAC.
// Latency: first byte one cycle after read data returns; free request one cycle after a block's last byte.
// Backpressure: tx_ready_i stalls streaming with output held; read and free requests hold until rvalid/gnt.
module egress_read_ctrl #(
    parameter int ADDR_W        = 10,
    parameter int PAYLOAD_BYTES = 8,
    parameter int CNT_W         = $clog2(PAYLOAD_BYTES + 1),
    parameter int BLOCK_BITS    = 8 * PAYLOAD_BYTES + CNT_W + 1 + ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  desc_valid_i,
    input  logic [ADDR_W-1:0]     desc_addr_i,
    output logic                  desc_ready_o,
    output logic                  mem_re_o,
    output logic [ADDR_W-1:0]     mem_raddr_o,
    input  logic                  mem_rvalid_i,
    input  logic [BLOCK_BITS-1:0] mem_rdata_i,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_sof_o,
    output logic                  tx_eof_o,
    input  logic                  tx_ready_i,
    output logic                  fl_free_req_o,
    output logic [ADDR_W-1:0]     fl_free_idx_o,
    input  logic                  fl_free_gnt_i,
    output logic                  err_o,
    output logic [15:0]           frames_sent_o
);

    localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, REQ, STREAM, FREE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_W-1:0]       cur_addr;
    logic [BLOCK_BITS-1:0]   blk;
    logic [IDX_W-1:0]        byte_idx;
    logic                    first;
    logic                    err_q;
    logic [15:0]             frames_sent;

    logic [ADDR_W-1:0]       blk_next;
    logic                    blk_last;
    logic [CNT_W-1:0]        blk_cnt;
    logic [CNT_W-1:0]        rd_cnt;
    logic                    rd_bad;
    logic                    byte_last;
    logic [7:0]              payload [PAYLOAD_BYTES];

    assign blk_next  = blk[ADDR_W-1:0];
    assign blk_last  = blk[ADDR_W];
    assign blk_cnt   = blk[ADDR_W+1 +: CNT_W];
    assign rd_cnt    = mem_rdata_i[ADDR_W+1 +: CNT_W];
    // A block with no bytes or more bytes than it can hold is dropped (freed, not streamed).
    assign rd_bad    = (rd_cnt == '0) || (rd_cnt > CNT_W'(PAYLOAD_BYTES));
    assign byte_last = (CNT_W'(byte_idx) == (blk_cnt - CNT_W'(1)));

    assign err_o         = err_q;
    assign frames_sent_o = frames_sent;

    // Unpack the latched block's payload into a byte array.
    always_comb begin
        for (int k = 0; k < PAYLOAD_BYTES; k++) begin
            payload[k] = blk[ADDR_W + 1 + CNT_W + 8*k +: 8];
        end
    end

    // State register; reset returns to IDLE so all requests drop with rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        state_nxt     = state;
        desc_ready_o  = 1'b0;
        mem_re_o      = 1'b0;
        mem_raddr_o   = '0;
        tx_valid_o    = 1'b0;
        tx_data_o     = '0;
        tx_sof_o      = 1'b0;
        tx_eof_o      = 1'b0;
        fl_free_req_o = 1'b0;
        fl_free_idx_o = '0;
        case (state)
            IDLE: begin
                desc_ready_o = 1'b1;
                if (desc_valid_i) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_re_o    = 1'b1;
                mem_raddr_o = cur_addr;
                if (mem_rvalid_i) begin
                    state_nxt = rd_bad ? FREE : STREAM;
                end
            end
            STREAM: begin
                tx_valid_o = 1'b1;
                tx_data_o  = payload[byte_idx];
                tx_sof_o   = first && (byte_idx == '0);
                tx_eof_o   = blk_last && byte_last;
                if (tx_ready_i && byte_last) begin
                    state_nxt = FREE;
                end
            end
            FREE: begin
                fl_free_req_o = 1'b1;
                fl_free_idx_o = cur_addr;
                if (fl_free_gnt_i) begin
                    state_nxt = blk_last ? IDLE : REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: block address, latched block, byte cursor, frame counter, error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr    <= '0;
            blk         <= '0;
            byte_idx    <= '0;
            first       <= 1'b0;
            err_q       <= 1'b0;
            frames_sent <= '0;
        end else begin
            err_q <= (state == REQ) && mem_rvalid_i && rd_bad;
            case (state)
                IDLE: begin
                    if (desc_valid_i) begin
                        cur_addr <= desc_addr_i;
                        first    <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_rvalid_i) begin
                        blk      <= mem_rdata_i;
                        byte_idx <= '0;
                    end
                end
                STREAM: begin
                    if (tx_ready_i) begin
                        byte_idx <= byte_idx + IDX_W'(1);
                        first    <= 1'b0;
                    end
                end
                FREE: begin
                    if (fl_free_gnt_i) begin
                        if (blk_last) begin
                            frames_sent <= frames_sent + 16'd1;
                        end else begin
                            cur_addr <= blk_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_egress_read_ctrl.sv
// Bench for egress_read_ctrl: directed scenarios plus randomized chains.
// Expected traffic comes from walking a table of blocks into queues of reads, bytes and frees.
// Memory and free-list responders use fixed or random latencies.
module tb_egress_read_ctrl;
    localparam int ADDR_W = 10;
    localparam int PB     = 8;
    localparam int CNT_W  = 4;
    localparam int BB     = 8 * PB + CNT_W + 1 + ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              desc_valid_i;
    logic [ADDR_W-1:0] desc_addr_i;
    logic              desc_ready_o;
    logic              mem_re_o;
    logic [ADDR_W-1:0] mem_raddr_o;
    logic              mem_rvalid_i;
    logic [BB-1:0]     mem_rdata_i;
    logic              tx_valid_o;
    logic [7:0]        tx_data_o;
    logic              tx_sof_o;
    logic              tx_eof_o;
    logic              tx_ready_i;
    logic              fl_free_req_o;
    logic [ADDR_W-1:0] fl_free_idx_o;
    logic              fl_free_gnt_i;
    logic              err_o;
    logic [15:0]       frames_sent_o;

    egress_read_ctrl #(.ADDR_W(ADDR_W), .PAYLOAD_BYTES(PB)) dut (
        .clk(clk), .rst_n(rst_n),
        .desc_valid_i(desc_valid_i), .desc_addr_i(desc_addr_i), .desc_ready_o(desc_ready_o),
        .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_sof_o(tx_sof_o), .tx_eof_o(tx_eof_o), .tx_ready_i(tx_ready_i),
        .fl_free_req_o(fl_free_req_o), .fl_free_idx_o(fl_free_idx_o), .fl_free_gnt_i(fl_free_gnt_i),
        .err_o(err_o), .frames_sent_o(frames_sent_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic void fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not expected by the model (cycle %0d)", nm, cyc);
    endfunction

    // Block table: the abstract contents of packet memory.
    int         t_next [1024];
    bit         t_last [1024];
    int         t_cnt  [1024];
    logic [7:0] t_pay  [1024][PB];

    function automatic void set_blk(input int a, input int nx, input bit ls, input int cnt,
                                    input logic [7:0] b0, input logic [7:0] st);
        logic [7:0] v;
        v = b0;
        t_next[a] = nx;
        t_last[a] = ls;
        t_cnt[a]  = cnt;
        for (int k = 0; k < PB; k++) begin
            t_pay[a][k] = v;
            v = v + st;
        end
    endfunction

    function automatic logic [BB-1:0] enc(input int a);
        logic [BB-1:0] r;
        r = '0;
        r[ADDR_W-1:0]       = ADDR_W'(t_next[a]);
        r[ADDR_W]           = t_last[a];
        r[ADDR_W+1 +: CNT_W] = CNT_W'(t_cnt[a]);
        for (int k = 0; k < PB; k++) r[ADDR_W + 1 + CNT_W + 8*k +: 8] = t_pay[a][k];
        return r;
    endfunction

    // Expected traffic queues.
    typedef struct { int addr; bit bad; bit last; } rd_t;
    typedef struct { logic [7:0] d; bit sof; bit eof; bit bend; } by_t;
    typedef struct { int addr; bit last; } fr_t;
    rd_t rd_q[$];
    by_t by_q[$];
    fr_t fr_q[$];
    int  exp_frames = 0;

    function automatic void model_frame(input int head);
        int a;
        bit first;
        bit bad;
        a = head;
        first = 1'b1;
        for (int g = 0; g < 64; g++) begin
            bad = (t_cnt[a] == 0) || (t_cnt[a] > PB);
            rd_q.push_back('{a, bad, t_last[a]});
            if (!bad) begin
                for (int k = 0; k < t_cnt[a]; k++) begin
                    by_q.push_back('{t_pay[a][k], first, t_last[a] && (k == t_cnt[a] - 1), k == t_cnt[a] - 1});
                    first = 1'b0;
                end
            end
            fr_q.push_back('{a, t_last[a]});
            if (t_last[a]) break;
            a = t_next[a];
        end
    endfunction

    // Observation logs for the hand-computed checks.
    logic [7:0] log_d[$];
    int         log_cyc[$];
    int         rd_log[$];
    int         fr_log[$];
    int         n_sof, n_eof, n_err, n_re;

    task automatic clear_logs();
        log_d.delete(); log_cyc.delete(); rd_log.delete(); fr_log.delete();
        n_sof = 0; n_eof = 0; n_err = 0; n_re = 0;
    endtask

    // Responders.
    int  rd_lat_fix = 0, gnt_lat_fix = 0, tx_mode = 0;
    int  rd_wait = -1, gnt_wait = -1, ph = 0;
    logic rv_resp = 1'b0, rv_spur = 1'b0;
    assign mem_rvalid_i = rv_resp | rv_spur;
    bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        mem_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            rv_resp = 1'b0;
            if (!rst_n) rd_wait = -1;
            else if (mem_re_o) begin
                if (rd_wait < 0) rd_wait = (rd_lat_fix >= 0) ? rd_lat_fix : int'($urandom_range(0, 4));
                if (rd_wait == 0) begin
                    rv_resp = 1'b1;
                    mem_rdata_i = enc(int'(mem_raddr_o));
                    rd_wait = -1;
                end else rd_wait--;
            end
        end
    end

    initial begin
        fl_free_gnt_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            fl_free_gnt_i = 1'b0;
            if (!rst_n) gnt_wait = -1;
            else if (fl_free_req_o) begin
                if (gnt_wait < 0) gnt_wait = (gnt_lat_fix >= 0) ? gnt_lat_fix : int'($urandom_range(0, 3));
                if (gnt_wait == 0) begin
                    fl_free_gnt_i = 1'b1;
                    gnt_wait = -1;
                end else gnt_wait--;
            end
        end
    end

    initial begin
        tx_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (tx_mode)
                1:       tx_ready_i = 1'($urandom_range(0, 1));
                2:       begin tx_ready_i = pat[ph % 4]; ph++; end
                default: tx_ready_i = 1'b1;
            endcase
        end
    end

    // Compare process: cycle-exact checks against the queues and one-cycle expectations.
    bit         exp_re_next, exp_stream_next, exp_free_next, exp_idle_next, exp_err_next;
    bit         prev_stall, prev_rwait;
    int         exp_re_addr, exp_free_addr;
    logic [9:0] prev_tx;
    logic [ADDR_W-1:0] prev_raddr;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_re_next = 0; exp_stream_next = 0; exp_free_next = 0; exp_idle_next = 0;
            exp_err_next = 0; prev_stall = 0; prev_rwait = 0;
        end else begin
            chk("frames_sent", frames_sent_o, exp_frames);
            chk("err_pulse", err_o, exp_err_next);
            if (exp_re_next) begin
                chk("re_next", mem_re_o, 1);
                chk("raddr_next", mem_raddr_o, exp_re_addr);
            end
            if (exp_stream_next) begin
                chk("first_byte_valid", tx_valid_o, 1);
                chk("re_drop", mem_re_o, 0);
            end
            if (exp_free_next) begin
                chk("free_req_next", fl_free_req_o, 1);
                chk("free_idx_next", fl_free_idx_o, exp_free_addr);
            end
            if (exp_idle_next) chk("ready_after_frame", desc_ready_o, 1);
            if (prev_stall) chk("stall_hold", {tx_valid_o, tx_sof_o, tx_eof_o, tx_data_o}, {1'b1, prev_tx});
            if (prev_rwait) chk("raddr_stable", {mem_re_o, mem_raddr_o}, {1'b1, prev_raddr});
            exp_re_next = 0; exp_stream_next = 0; exp_free_next = 0; exp_idle_next = 0; exp_err_next = 0;

            if (mem_re_o) n_re++;
            if (err_o) n_err++;
            if (desc_valid_i && desc_ready_o) begin
                exp_re_next = 1;
                exp_re_addr = int'(desc_addr_i);
            end
            if (mem_re_o && mem_rvalid_i) begin
                rd_log.push_back(int'(mem_raddr_o));
                if (rd_q.size() == 0) fail("unexpected_read");
                else begin
                    rd_t e;
                    e = rd_q.pop_front();
                    chk("read_addr", mem_raddr_o, e.addr);
                    if (e.bad) begin
                        exp_err_next = 1; exp_free_next = 1; exp_free_addr = e.addr;
                    end else exp_stream_next = 1;
                end
            end
            prev_rwait = mem_re_o && !mem_rvalid_i;
            prev_raddr = mem_raddr_o;
            prev_stall = tx_valid_o && !tx_ready_i;
            prev_tx    = {tx_sof_o, tx_eof_o, tx_data_o};
            if (tx_valid_o && tx_ready_i) begin
                log_d.push_back(tx_data_o);
                log_cyc.push_back(cyc);
                n_sof += int'(tx_sof_o);
                n_eof += int'(tx_eof_o);
                if (by_q.size() == 0) fail("unexpected_byte");
                else begin
                    by_t b;
                    b = by_q.pop_front();
                    chk("byte", {tx_sof_o, tx_eof_o, tx_data_o}, {b.sof, b.eof, b.d});
                    if (b.bend) begin
                        exp_free_next = 1;
                        exp_free_addr = (fr_q.size() > 0) ? fr_q[0].addr : -1;
                    end
                end
            end
            if (fl_free_req_o && fl_free_gnt_i) begin
                fr_log.push_back(int'(fl_free_idx_o));
                if (fr_q.size() == 0) fail("unexpected_free");
                else begin
                    fr_t f;
                    f = fr_q.pop_front();
                    chk("free_idx", fl_free_idx_o, f.addr);
                    if (f.last) begin
                        exp_frames = (exp_frames + 1) % 65536;
                        exp_idle_next = 1;
                    end else begin
                        exp_re_next = 1;
                        exp_re_addr = (rd_q.size() > 0) ? rd_q[0].addr : -1;
                    end
                end
            end
        end
    end

    task automatic send_frame(input int head);
        bit acc;
        acc = 0;
        @(posedge clk); #1;
        desc_valid_i = 1'b1;
        desc_addr_i  = ADDR_W'(head);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (desc_ready_o) begin
                acc = 1;
                model_frame(head);
                break;
            end
        end
        @(posedge clk); #1;
        desc_valid_i = 1'b0;
        if (!acc) fail("desc_accept_timeout");
    endtask

    task automatic wait_done(input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rd_q.size() == 0 && by_q.size() == 0 && fr_q.size() == 0 && desc_ready_o) begin
                done = 1;
                break;
            end
        end
        if (!done) fail("frame_completion_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_desc_ready"}, desc_ready_o, 1);
        chk({tag, "_quiet"}, {mem_re_o, tx_valid_o, tx_sof_o, tx_eof_o, fl_free_req_o, err_o}, 0);
        chk({tag, "_addr_data"}, {mem_raddr_o, fl_free_idx_o, tx_data_o}, 0);
        chk({tag, "_frames"}, frames_sent_o, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int r;
        int cnt;
        rst_n = 1'b0; desc_valid_i = 1'b0; desc_addr_i = '0;
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Single block, 5 bytes.
        set_blk(5, 0, 1, 5, 8'h11, 8'h11);
        clear_logs();
        send_frame(5);
        wait_done(200);
        chk("t1_nbytes", log_d.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < log_d.size()) begin
                chk("t1_byte", log_d[i], 8'h11 * (i + 1));
                chk("t1_back_to_back", log_cyc[i] - log_cyc[0], i);
            end
        end
        chk("t1_sof_eof", {n_sof, n_eof}, {32'd1, 32'd1});
        chk("t1_free", (fr_log.size() == 1) ? fr_log[0] : -1, 5);
        chk("t1_frames", frames_sent_o, 1);

        // Three-block chain 20 -> 21 -> 22.
        set_blk(20, 21, 0, 8, 8'h00, 8'h01);
        set_blk(21, 22, 0, 8, 8'h40, 8'h03);
        set_blk(22, 0, 1, 3, 8'hC0, 8'h05);
        clear_logs();
        send_frame(20);
        wait_done(400);
        chk("t2_nbytes", log_d.size(), 19);
        chk("t2_reads", (rd_log.size() == 3) ? {rd_log[0][9:0], rd_log[1][9:0], rd_log[2][9:0]} : 0, {10'd20, 10'd21, 10'd22});
        chk("t2_frees", (fr_log.size() == 3) ? {fr_log[0][9:0], fr_log[1][9:0], fr_log[2][9:0]} : 0, {10'd20, 10'd21, 10'd22});
        chk("t2_sof_eof", {n_sof, n_eof}, {32'd1, 32'd1});
        chk("t2_frames", frames_sent_o, 2);

        // Stalling TX MAC with a 1,0,0,1 ready pattern.
        set_blk(30, 0, 1, 8, 8'hA0, 8'h01);
        clear_logs();
        tx_mode = 2;
        send_frame(30);
        wait_done(400);
        tx_mode = 0;
        chk("t3_nbytes", log_d.size(), 8);
        for (int i = 0; i < 8; i++) if (i < log_d.size()) chk("t3_byte", log_d[i], 8'hA0 + i);

        // Spurious rvalid while idle, then a read delayed by 4 cycles.
        @(posedge clk); #1 rv_spur = 1'b1;
        @(posedge clk); #1 rv_spur = 1'b0;
        @(negedge clk);
        chk("t4_spurious_ignored", {desc_ready_o, mem_re_o, tx_valid_o, err_o}, 4'b1000);
        rd_lat_fix = 4;
        set_blk(40, 0, 1, 6, 8'h61, 8'h02);
        clear_logs();
        send_frame(40);
        wait_done(400);
        rd_lat_fix = 0;
        chk("t4_req_cycles", n_re, 5);
        chk("t4_nbytes", log_d.size(), 6);

        // Malformed head block followed by a good block.
        set_blk(50, 51, 0, 0, 8'hEE, 8'h01);
        set_blk(51, 0, 1, 4, 8'h71, 8'h01);
        clear_logs();
        send_frame(50);
        wait_done(400);
        chk("t5_err_count", n_err, 1);
        chk("t5_nbytes", log_d.size(), 4);
        chk("t5_frees", (fr_log.size() == 2) ? {fr_log[0][9:0], fr_log[1][9:0]} : 0, {10'd50, 10'd51});
        chk("t5_sof_eof", {n_sof, n_eof}, {32'd1, 32'd1});

        // Reset in the middle of a two-block frame, then a fresh frame.
        set_blk(60, 61, 0, 8, 8'h80, 8'h01);
        set_blk(61, 0, 1, 8, 8'h90, 8'h01);
        send_frame(60);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_valid_o) break;
        end
        chk("t6_streaming", tx_valid_o, 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6_async_reset");
        rd_q.delete(); by_q.delete(); fr_q.delete();
        exp_frames = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        clear_logs();
        send_frame(5);
        wait_done(200);
        chk("t6_nbytes", log_d.size(), 5);
        if (log_d.size() == 5) chk("t6_last_byte", log_d[4], 8'h55);
        chk("t6_frames", frames_sent_o, 1);

        // Randomized chains with random latencies and backpressure.
        tx_mode = 1; rd_lat_fix = -1; gnt_lat_fix = -1;
        for (int f = 0; f < 40; f++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                r = $urandom_range(0, 19);
                cnt = (r == 0) ? 0 : (r == 1) ? int'($urandom_range(9, 15)) : int'($urandom_range(1, 8));
                set_blk(100 + f*4 + b, 100 + f*4 + b + 1, b == nb - 1, cnt,
                        8'($urandom), 8'($urandom));
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_frame(100 + f*4);
        end
        wait_done(3000);
        chk("rand_frames", frames_sent_o, 41);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/egress_read_ctrl.md
# egress_read_ctrl

Per-egress-port frame reader; one instance per port. It accepts a frame descriptor (the head block address), walks the frame's linked list of memory blocks through the shared arbitrated read port, and streams payload bytes to the TX MAC with valid/ready. After the TX MAC takes the last byte of a block, the block is returned to the free list.

## Interface
- ADDR_W, 10, block address width
- PAYLOAD_BYTES, 8, payload bytes per block
- CNT_W, $clog2(PAYLOAD_BYTES+1), width of the byte-count field
- BLOCK_BITS, 8*PAYLOAD_BYTES+CNT_W+1+ADDR_W, block width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- desc_valid_i  in  1  frame descriptor valid
- desc_addr_i  in  ADDR_W  head block address of the frame
- desc_ready_o  out  1  descriptor accepted when valid & ready
- mem_re_o  out  1  read request to the arbiter
- mem_raddr_o  out  ADDR_W  read address
- mem_rvalid_i  in  1  read data valid (routed by the arbiter)
- mem_rdata_i  in  BLOCK_BITS  read data
- tx_valid_o  out  1  byte valid to the TX MAC
- tx_data_o  out  8  payload byte
- tx_sof_o  out  1  first byte of the frame (qualified by tx_valid_o)
- tx_eof_o  out  1  last byte of the frame (qualified by tx_valid_o)
- tx_ready_i  in  1  TX MAC accepts the byte
- fl_free_req_o  out  1  free-block request
- fl_free_idx_o  out  ADDR_W  block being freed
- fl_free_gnt_i  in  1  free list accepted the request
- err_o  out  1  one-cycle malformed-block pulse
- frames_sent_o  out  16  count of completed frames, wraps at 65535→0

## Operation
- Block layout:
  - [ADDR_W-1:0] is next_ptr.
  - [ADDR_W] is last.
  - [ADDR_W+1 +: CNT_W] is byte_cnt.
  - Payload occupies the remaining bits. Byte k is at [ADDR_W+1+CNT_W+8k +: 8].
- FSM states: IDLE, REQ, STREAM, FREE.
- IDLE:
  - desc_ready_o=1.
  - On handshake: cur_addr←desc_addr_i, first←1, go to REQ.
- REQ:
  - mem_re_o=1 and mem_raddr_o=cur_addr, both held stable until mem_rvalid_i.
  - On mem_rvalid_i: latch the block, byte_idx←0, go to STREAM.
- STREAM:
  - tx_valid_o=1, tx_data_o=payload[byte_idx].
  - tx_sof_o=first && byte_idx==0.
  - tx_eof_o=last && byte_idx==byte_cnt-1.
  - On tx_ready_i: byte_idx++ and first←0.
  - After the handshake on byte byte_cnt-1, go to FREE.
- FREE:
  - fl_free_req_o=1, fl_free_idx_o=cur_addr, held until fl_free_gnt_i.
  - On gnt with last=1: frames_sent_o++, go to IDLE.
  - On gnt with last=0: cur_addr←next_ptr, go to REQ.
- Malformed block (byte_cnt==0 or byte_cnt>PAYLOAD_BYTES):
  - err_o pulses in the cycle after rvalid.
  - STREAM is skipped; the block goes straight to FREE.
  - The last/next handling is unchanged.
  - No tx_eof_o is generated for that block.
- mem_rvalid_i outside REQ is ignored.
- fl_free_gnt_i outside FREE is ignored.
- Blocks are freed strictly in chain order, one request at a time.

## Timing
- Reset values: state=IDLE; all outputs 0 except desc_ready_o=1; frames_sent_o=0; block register and cur_addr=0.
- Descriptor accepted at edge T:
  - mem_re_o rises in cycle T+1.
  - Read latency is arbitrary (≥1 cycle); the port holds its request.
- rvalid sampled at edge R:
  - mem_re_o=0 in cycle R+1.
  - tx_valid_o=1 in cycle R+1 (first byte).
- One byte per cycle under continuous tx_ready_i.
- tx_valid_o/tx_data_o are stable while tx_ready_i=0.
- Last byte accepted at edge L: fl_free_req_o=1 in cycle L+1.
- Free granted at edge G:
  - Next block: mem_re_o=1 in cycle G+1.
  - End of frame: desc_ready_o=1 in cycle G+1, and frames_sent_o updates at G.
- Per-block overhead beyond streaming: 1 REQ cycle + read latency + ≥1 FREE cycle.
- Asynchronous reset mid-frame:
  - Immediate return to IDLE.
  - All requests drop combinationally with the reset.
  - The outstanding block is not freed (a system reset reinitialises the free list).

## Test plan
- Single block, byte_cnt=5, last=1, payload 0x11..0x55, tx_ready_i tied 1, rvalid 1 cycle after re:
  - Bytes 11,22,33,44,55 on consecutive cycles.
  - sof on 0x11, eof on 0x55.
  - Free of the head address follows; frames_sent_o=1.
- Three-block chain A→B→C with byte_cnt 8,8,3:
  - 19 bytes delivered.
  - Reads issued to A, B, C in order; frees issued to A, B, C in order.
  - Exactly one sof and one eof.
- tx_ready_i toggling 1,0,0,1 during STREAM: data is held across stalls; no bytes are lost or duplicated.
- rvalid delayed 4 cycles, plus a spurious rvalid pulse while in IDLE:
  - mem_raddr_o is stable through the delay.
  - The spurious pulse causes no state change.
- Block with byte_cnt=0, last=0, next=B:
  - err_o pulses once.
  - No tx_valid_o for that block.
  - The block is freed, then B is read and streamed normally.
- rst_n asserted mid-STREAM of a two-block frame:
  - Outputs go to reset values immediately.
  - After release, a new descriptor is accepted and sent correctly.
